// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register with load-use hazard detection and a
// saturating bubble counter.
//
// On each rising edge of clk the register takes exactly one action, checked in
// this order:
//   reset    -> every ex_* output, ex_valid and bubble_cnt go to 0
//   flush    -> bubble: ex_* and ex_valid go to 0, bubble_cnt counts up
//   lu_stall -> bubble, the same as flush (E is ignored)
//   E = 0    -> hold: nothing changes
//   E = 1    -> load: every id_* field moves to its ex_* counterpart
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   E                       load enable
//   flush                   squash request from a taken branch
//   id_*                    decode-stage fields to register
//   id_rn/id_rm/id_uses_*   source registers, used only for hazard detection
//   ex_*                    registered copies of the decode fields
//   ex_valid                execute slot holds a real instruction
//   lu_stall                load-use hazard; the PC and IF_ID enables are
//                           driven low while it is set
//   bubble_cnt              number of inserted bubbles, saturating at 255
// -----------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        E,
  input  logic        flush,
  input  logic [3:0]  id_alu_op,
  input  logic [1:0]  id_am,
  input  logic        id_load,
  input  logic        id_mem_write,
  input  logic        id_store_cc,
  input  logic        id_b,
  input  logic        id_bl,
  input  logic        id_mem_size,
  input  logic        id_mem_e,
  input  logic        id_rf_e,
  input  logic        id_valid,
  input  logic [31:0] id_pa,
  input  logic [31:0] id_pb,
  input  logic [31:0] id_pd,
  input  logic [3:0]  id_rd,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic [11:0] id_shift,
  input  logic [31:0] id_next_pc,
  input  logic [3:0]  id_cond,
  output logic [3:0]  ex_alu_op,
  output logic [1:0]  ex_am,
  output logic        ex_load,
  output logic        ex_mem_write,
  output logic        ex_store_cc,
  output logic        ex_b,
  output logic        ex_bl,
  output logic        ex_mem_size,
  output logic        ex_mem_e,
  output logic        ex_rf_e,
  output logic [31:0] ex_pa,
  output logic [31:0] ex_pb,
  output logic [31:0] ex_pd,
  output logic [3:0]  ex_rd,
  output logic [11:0] ex_shift,
  output logic [31:0] ex_next_pc,
  output logic [3:0]  ex_cond,
  output logic        ex_valid,
  output logic        lu_stall,
  output logic [7:0]  bubble_cnt
);

  // One instruction slot. Clearing this struct as a whole produces a bubble.
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  am;
    logic        load;
    logic        mem_write;
    logic        store_cc;
    logic        b;
    logic        bl;
    logic        mem_size;
    logic        mem_e;
    logic        rf_e;
    logic        valid;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pd;
    logic [3:0]  rd;
    logic [11:0] shift;
    logic [31:0] next_pc;
    logic [3:0]  cond;
  } slot_t;

  slot_t      id_slot;
  slot_t      ex_q;
  logic       bubble;
  logic       rn_hit;
  logic       rm_hit;
  logic [7:0] bubble_cnt_q;

  // Gather the decode fields into a slot. An instruction with id_valid=0 is
  // still loaded bit for bit; its fields are not cleared on the way in.
  always_comb begin
    id_slot           = '0;
    id_slot.alu_op    = id_alu_op;
    id_slot.am        = id_am;
    id_slot.load      = id_load;
    id_slot.mem_write = id_mem_write;
    id_slot.store_cc  = id_store_cc;
    id_slot.b         = id_b;
    id_slot.bl        = id_bl;
    id_slot.mem_size  = id_mem_size;
    id_slot.mem_e     = id_mem_e;
    id_slot.rf_e      = id_rf_e;
    id_slot.valid     = id_valid;
    id_slot.pa        = id_pa;
    id_slot.pb        = id_pb;
    id_slot.pd        = id_pd;
    id_slot.rd        = id_rd;
    id_slot.shift     = id_shift;
    id_slot.next_pc   = id_next_pc;
    id_slot.cond      = id_cond;
  end

  // Load-use hazard: a valid load in execute that writes a register the
  // decoding instruction reads. The compare uses all four bits, so R15 gets no
  // special treatment. A bubble clears ex_valid, so the stall drops by itself
  // after exactly one bubble. Reset clears ex_valid too, which keeps the stall
  // low in the reset state.
  assign rn_hit   = id_uses_rn && (id_rn == ex_q.rd);
  assign rm_hit   = id_uses_rm && (id_rm == ex_q.rd);
  assign lu_stall = ex_q.valid && ex_q.load && ex_q.rf_e && id_valid &&
                    (rn_hit || rm_hit);

  // A flush and a load-use stall on the same edge give a single bubble.
  assign bubble = flush || lu_stall;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else if (bubble) begin
      ex_q <= '0;
      // The counter stops at 255 and never wraps.
      if (bubble_cnt_q != 8'hFF) begin
        bubble_cnt_q <= bubble_cnt_q + 8'd1;
      end
    end else if (E) begin
      ex_q <= id_slot;
    end
    // With E=0 and no bubble every flop holds its value.
  end

  assign ex_alu_op    = ex_q.alu_op;
  assign ex_am        = ex_q.am;
  assign ex_load      = ex_q.load;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_store_cc  = ex_q.store_cc;
  assign ex_b         = ex_q.b;
  assign ex_bl        = ex_q.bl;
  assign ex_mem_size  = ex_q.mem_size;
  assign ex_mem_e     = ex_q.mem_e;
  assign ex_rf_e      = ex_q.rf_e;
  assign ex_pa        = ex_q.pa;
  assign ex_pb        = ex_q.pb;
  assign ex_pd        = ex_q.pd;
  assign ex_rd        = ex_q.rd;
  assign ex_shift     = ex_q.shift;
  assign ex_next_pc   = ex_q.next_pc;
  assign ex_cond      = ex_q.cond;
  assign ex_valid     = ex_q.valid;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. Directed scenarios cover basic load,
// hold, the load-use bubble, flush taking precedence, counter saturation and
// reset. These are followed by randomized cycles. Each cycle is checked
// against a reference model that works at the instruction level: a single
// "execute slot" record and a bubble tally.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  am;
    logic        load, mem_write, store_cc, b, bl, mem_size, mem_e, rf_e;
    logic        valid;
    logic [31:0] pa, pb, pd;
    logic [3:0]  rd, rn, rm;
    logic        uses_rn, uses_rm;
    logic [11:0] shift;
    logic [31:0] next_pc;
    logic [3:0]  cond;
  } instr_t;

  logic   clk = 1'b0;
  logic   reset, E, flush;
  instr_t id;

  logic [3:0]  ex_alu_op, ex_rd, ex_cond;
  logic [1:0]  ex_am;
  logic        ex_load, ex_mem_write, ex_store_cc, ex_b, ex_bl;
  logic        ex_mem_size, ex_mem_e, ex_rf_e, ex_valid, lu_stall;
  logic [31:0] ex_pa, ex_pb, ex_pd, ex_next_pc;
  logic [11:0] ex_shift;
  logic [7:0]  bubble_cnt;

  // Reference model: the instruction held in execute, and the bubble tally.
  instr_t m_ex, m_next;
  int     m_cnt, m_cnt_next;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .E(E), .flush(flush),
    .id_alu_op(id.alu_op), .id_am(id.am), .id_load(id.load),
    .id_mem_write(id.mem_write), .id_store_cc(id.store_cc), .id_b(id.b),
    .id_bl(id.bl), .id_mem_size(id.mem_size), .id_mem_e(id.mem_e),
    .id_rf_e(id.rf_e), .id_valid(id.valid), .id_pa(id.pa), .id_pb(id.pb),
    .id_pd(id.pd), .id_rd(id.rd), .id_rn(id.rn), .id_rm(id.rm),
    .id_uses_rn(id.uses_rn), .id_uses_rm(id.uses_rm), .id_shift(id.shift),
    .id_next_pc(id.next_pc), .id_cond(id.cond),
    .ex_alu_op(ex_alu_op), .ex_am(ex_am), .ex_load(ex_load),
    .ex_mem_write(ex_mem_write), .ex_store_cc(ex_store_cc), .ex_b(ex_b),
    .ex_bl(ex_bl), .ex_mem_size(ex_mem_size), .ex_mem_e(ex_mem_e),
    .ex_rf_e(ex_rf_e), .ex_pa(ex_pa), .ex_pb(ex_pb), .ex_pd(ex_pd),
    .ex_rd(ex_rd), .ex_shift(ex_shift), .ex_next_pc(ex_next_pc),
    .ex_cond(ex_cond), .ex_valid(ex_valid), .lu_stall(lu_stall),
    .bubble_cnt(bubble_cnt)
  );

  wire [162:0] dut_bundle = {ex_alu_op, ex_am, ex_load, ex_mem_write,
    ex_store_cc, ex_b, ex_bl, ex_mem_size, ex_mem_e, ex_rf_e, ex_valid,
    ex_pa, ex_pb, ex_pd, ex_rd, ex_shift, ex_next_pc, ex_cond};

  function automatic logic [162:0] model_bundle(input instr_t s);
    return {s.alu_op, s.am, s.load, s.mem_write, s.store_cc, s.b, s.bl,
            s.mem_size, s.mem_e, s.rf_e, s.valid, s.pa, s.pb, s.pd, s.rd,
            s.shift, s.next_pc, s.cond};
  endfunction

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The decoding instruction reads a register that the valid load in execute
  // is about to write.
  function automatic logic model_hazard();
    logic reads_it;
    reads_it = (id.uses_rn && id.rn == m_ex.rd) ||
               (id.uses_rm && id.rm == m_ex.rd);
    return m_ex.valid && m_ex.load && m_ex.rf_e && id.valid && reads_it;
  endfunction

  // One clock edge: check the combinational stall before the edge, predict
  // the edge's effect, then check every output just after it.
  task automatic step();
    logic hz;
    @(negedge clk);
    hz = model_hazard();
    check("lu_stall", 256'(lu_stall), 256'(hz));
    m_next     = m_ex;
    m_cnt_next = m_cnt;
    if (reset) begin
      m_next     = '0;
      m_cnt_next = 0;
    end else if (flush || hz) begin
      m_next     = '0;
      m_cnt_next = (m_cnt < 255) ? m_cnt + 1 : 255;
    end else if (E) begin
      m_next         = id;
      m_next.rn      = '0;
      m_next.rm      = '0;
      m_next.uses_rn = 1'b0;
      m_next.uses_rm = 1'b0;
    end
    @(posedge clk);
    #1;
    m_ex  = m_next;
    m_cnt = m_cnt_next;
    check("ex_bundle", 256'(dut_bundle), 256'(model_bundle(m_ex)));
    check("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt));
  endtask

  task automatic random_id(input int reg_max);
    id.alu_op    = 4'($urandom);
    id.am        = 2'($urandom);
    id.load      = 1'($urandom);
    id.mem_write = 1'($urandom);
    id.store_cc  = 1'($urandom);
    id.b         = 1'($urandom);
    id.bl        = 1'($urandom);
    id.mem_size  = 1'($urandom);
    id.mem_e     = 1'($urandom);
    id.rf_e      = ($urandom_range(0, 3) != 0);
    id.valid     = ($urandom_range(0, 4) != 0);
    id.pa        = $urandom;
    id.pb        = $urandom;
    id.pd        = $urandom;
    id.rd        = 4'($urandom_range(0, reg_max));
    id.rn        = 4'($urandom_range(0, reg_max));
    id.rm        = 4'($urandom_range(0, reg_max));
    id.uses_rn   = 1'($urandom);
    id.uses_rm   = 1'($urandom);
    id.shift     = 12'($urandom);
    id.next_pc   = $urandom;
    id.cond      = 4'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    id    = '0;
    E     = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    m_ex  = '0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    check("rst_bundle", 256'(dut_bundle), 256'(0));
    check("rst_cnt", 256'(bubble_cnt), 256'(0));
    check("rst_lu", 256'(lu_stall), 256'(0));
    reset = 1'b0;

    // Basic load.
    E = 1'b1; id.valid = 1'b1; id.alu_op = 4'b0100; id.pa = 32'h5; id.rd = 4'h3;
    step();
    check("load_alu_op", 256'(ex_alu_op), 256'(4'b0100));
    check("load_pa", 256'(ex_pa), 256'(32'h5));
    check("load_rd", 256'(ex_rd), 256'(4'h3));
    check("load_valid", 256'(ex_valid), 256'(1));
    check("load_cnt", 256'(bubble_cnt), 256'(0));

    // Hold for three cycles.
    E = 1'b0; id.pa = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_pa", 256'(ex_pa), 256'(32'h5));
      check("hold_valid", 256'(ex_valid), 256'(1));
    end

    // Load-use: a load to R2 in execute, then a reader of R2 in decode.
    E = 1'b1; id = '0; id.valid = 1'b1; id.load = 1'b1; id.rf_e = 1'b1; id.rd = 4'h2;
    step();
    id = '0; id.valid = 1'b1; id.rn = 4'h2; id.uses_rn = 1'b1; id.rd = 4'h5;
    id.alu_op = 4'h9;
    #1;
    check("lu_set", 256'(lu_stall), 256'(1));
    step();
    check("lu_bubble_valid", 256'(ex_valid), 256'(0));
    check("lu_bubble_load", 256'(ex_load), 256'(0));
    check("lu_bubble_cnt", 256'(bubble_cnt), 256'(1));
    check("lu_clear", 256'(lu_stall), 256'(0));
    step();
    check("lu_reload_valid", 256'(ex_valid), 256'(1));
    check("lu_reload_rd", 256'(ex_rd), 256'(4'h5));

    // Flush together with a load-use hazard gives one bubble.
    id = '0; id.valid = 1'b1; id.load = 1'b1; id.rf_e = 1'b1; id.rd = 4'h2;
    step();
    id = '0; id.valid = 1'b1; id.rm = 4'h2; id.uses_rm = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_lu_set", 256'(lu_stall), 256'(1));
    c0 = m_cnt;
    step();
    check("fl_valid", 256'(ex_valid), 256'(0));
    check("fl_cnt", 256'(bubble_cnt), 256'(c0 + 1));

    // Saturation: 300 flushes in a row.
    for (int i = 0; i < 300; i++) step();
    check("sat_cnt", 256'(bubble_cnt), 256'(255));

    // Reset wins over the load enable.
    flush = 1'b0; reset = 1'b1; E = 1'b1; random_id(15); id.valid = 1'b1;
    step();
    check("rst2_bundle", 256'(dut_bundle), 256'(0));
    check("rst2_cnt", 256'(bubble_cnt), 256'(0));
    reset = 1'b0;

    // Randomized traffic. A small register range makes hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      random_id(3);
      E     = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
